// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the bcd_stopwatch core: state encoding, BCD digit
// type, display payload and binary-to-BCD conversion.
package stopwatch_pkg;

  localparam int unsigned SECS_PER_MIN = 60;
  localparam int unsigned MIN_W        = 7;
  localparam int unsigned SEC_W        = 6;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_ADJUST = 2'd2
  } state_e;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t min10;
    bcd_t min1;
    bcd_t sec10;
    bcd_t sec1;
  } time_bcd_t;

  // Two-digit BCD of a binary value below 100.
  function automatic logic [7:0] bin_to_bcd(input logic [MIN_W-1:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Modulo-N enable counter with synchronous clear; tc_c_o is high during the
// enabled cycle that holds the last count.
module tick_gen #(
  parameter int unsigned N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_c_o
);

  localparam int unsigned W = (N > 2) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_c_o = en_i && (cnt_q == LAST);

  // Clear wins over counting; the terminal-count output of that cycle still fires.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bcd_stopwatch.sv
// mm:ss stopwatch core with run/pause/adjust control and saturation at MAX_MIN:59.
// Optional lap hold on the display is built when LAP_EN is defined.
module bcd_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned ADJ_DIV  = 50_000_000,
  parameter int unsigned MAX_MIN  = 59,
  parameter int unsigned ADJ_STEP = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pause_pulse,
  input  logic       lap_pulse,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] min10,
  output logic [3:0] min1,
  output logic [3:0] sec10,
  output logic [3:0] sec1,
  output logic       running,
  output logic       blink
);

  localparam logic [MIN_W-1:0] MAX_MIN_V  = MIN_W'(MAX_MIN);
  localparam logic [SEC_W-1:0] LAST_SEC_V = SEC_W'(SECS_PER_MIN - 1);

  state_e                  state_q, state_d;
  logic                    paused_q, paused_d;
  logic [MIN_W-1:0]        min_q, min_d;
  logic [SEC_W-1:0]        sec_q, sec_d;
  time_bcd_t               disp_q, disp_d, live;
  logic                    running_q, running_d;
  logic                    blink_q, blink_d;
  logic                    sec_en, adj_en, adj_entry;
  logic                    sec_tc, adj_tc;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      paused_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      paused_q <= paused_d;
    end
  end

  // Next state: adj dominates, otherwise the (post-toggle) pause flag decides.
  always_comb begin
    paused_d = paused_q ^ pause_pulse;
    state_d  = ST_RUN;
    if (adj) begin
      state_d = ST_ADJUST;
    end else if (paused_d) begin
      state_d = ST_PAUSED;
    end
  end

  assign sec_en    = (state_q == ST_RUN);
  assign adj_en    = (state_q == ST_ADJUST);
  assign adj_entry = (state_d == ST_ADJUST) && (state_q != ST_ADJUST);

  // Output decode for the registered running/blink flags.
  always_comb begin
    running_d = (state_d == ST_RUN);
    blink_d   = 1'b1;
    if (state_d == ST_ADJUST) begin
      blink_d = adj_tc ? ~blink_q : blink_q;
    end
  end

  tick_gen #(.N(TICK_DIV)) u_sec_tick (
    .clk    (clk),
    .rst    (rst),
    .en_i   (sec_en),
    .clr_i  (adj_entry),
    .tc_c_o (sec_tc)
  );

  tick_gen #(.N(ADJ_DIV)) u_adj_tick (
    .clk    (clk),
    .rst    (rst),
    .en_i   (adj_en),
    .clr_i  (adj_entry),
    .tc_c_o (adj_tc)
  );

  // Binary time update; second ticks and adjust steps are mutually exclusive.
  always_comb begin
    min_d = min_q;
    sec_d = sec_q;
    if (sec_tc) begin
      if (sec_q != LAST_SEC_V) begin
        sec_d = sec_q + SEC_W'(1);
      end else if (min_q != MAX_MIN_V) begin
        sec_d = '0;
        min_d = min_q + MIN_W'(1);
      end
    end
    if (adj_tc) begin
      if (!sel) begin
        sec_d = SEC_W'((32'(sec_q) + ADJ_STEP) % SECS_PER_MIN);
      end else begin
        min_d = MIN_W'((32'(min_q) + ADJ_STEP) % (MAX_MIN + 1));
      end
    end
  end

  always_comb begin
    live = {bin_to_bcd(min_d), bin_to_bcd({1'b0, sec_d})};
  end

`ifdef LAP_EN
  logic lap_q, lap_d;

  // Entering adjust drops any lap hold so the edited value is visible.
  always_comb begin
    lap_d = lap_q ^ lap_pulse;
    if (adj_entry) begin
      lap_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lap_q <= 1'b0;
    end else begin
      lap_q <= lap_d;
    end
  end

  assign disp_d = lap_d ? disp_q : live;
`else
  logic lap_unused;
  assign lap_unused = lap_pulse;
  assign disp_d     = live;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      min_q     <= '0;
      sec_q     <= '0;
      disp_q    <= '0;
      running_q <= 1'b1;
      blink_q   <= 1'b1;
    end else begin
      min_q     <= min_d;
      sec_q     <= sec_d;
      disp_q    <= disp_d;
      running_q <= running_d;
      blink_q   <= blink_d;
    end
  end

  assign min10   = disp_q.min10;
  assign min1    = disp_q.min1;
  assign sec10   = disp_q.sec10;
  assign sec1    = disp_q.sec1;
  assign running = running_q;
  assign blink   = blink_q;

endmodule
